// File: rtl/parking_gate_pkg.sv
// Shared types and constants for the parking gate front-end.
package parking_gate_pkg;

    localparam int unsigned SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        IDLE,
        IN_A,
        IN_AB,
        IN_B,
        OUT_B,
        OUT_BA,
        OUT_A,
        ABORT
    } gate_state_t;

endpackage

// File: rtl/gate_direction_detector_if.sv
// Beam-sensor / pulse bundle for one lane's direction detector.
// fault and fault_clr exist only when GATE_FAULT_EN is defined.
interface gate_direction_detector_if;

    logic beam_a_raw;
    logic beam_b_raw;
    logic entry_pulse;
    logic exit_pulse;
    logic lane_busy;
`ifdef GATE_FAULT_EN
    logic fault;
    logic fault_clr;

    modport master (
        output beam_a_raw, beam_b_raw, fault_clr,
        input  entry_pulse, exit_pulse, lane_busy, fault
    );
    modport slave (
        input  beam_a_raw, beam_b_raw, fault_clr,
        output entry_pulse, exit_pulse, lane_busy, fault
    );
`else
    modport master (
        output beam_a_raw, beam_b_raw,
        input  entry_pulse, exit_pulse, lane_busy
    );
    modport slave (
        input  beam_a_raw, beam_b_raw,
        output entry_pulse, exit_pulse, lane_busy
    );
`endif

endinterface

// File: rtl/sensor_debounce.sv
// Synchroniser plus stable-count debouncer for one raw beam sensor.
module sensor_debounce
    import parking_gate_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   level_q, level_d;

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (synced != level_q) begin
            if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = synced;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/gate_direction_detector.sv
// Beam-order decoder for one lane: debounced A/B levels drive an entry/exit FSM with timeout.
// Define GATE_FAULT_EN to expose the sticky fault flag and its clear input.
module gate_direction_detector
    import parking_gate_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 64
) (
    input logic                      clk,
    input logic                      reset,
    gate_direction_detector_if.slave gate
);

    localparam int unsigned DwellW = $clog2(TIMEOUT_CYCLES + 1);

    logic              a, b;
    gate_state_t       state_q, state_d;
    logic [DwellW-1:0] dwell_q, dwell_d;
    logic              entry_q, entry_d;
    logic              exit_q, exit_d;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk  (clk),
        .reset(reset),
        .raw  (gate.beam_a_raw),
        .level(a)
    );

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk  (clk),
        .reset(reset),
        .raw  (gate.beam_b_raw),
        .level(b)
    );

    always_comb begin
        state_d = state_q;
        entry_d = 1'b0;
        exit_d  = 1'b0;
        unique case (state_q)
            IDLE: case ({a, b})
                2'b10:   state_d = IN_A;
                2'b01:   state_d = OUT_B;
                2'b11:   state_d = ABORT;
                default: state_d = IDLE;
            endcase
            IN_A: case ({a, b})
                2'b11:   state_d = IN_AB;
                2'b00:   state_d = IDLE;
                2'b01:   state_d = ABORT;
                default: state_d = IN_A;
            endcase
            IN_AB: case ({a, b})
                2'b01:   state_d = IN_B;
                2'b10:   state_d = IN_A;
                2'b00:   state_d = ABORT;
                default: state_d = IN_AB;
            endcase
            IN_B: case ({a, b})
                2'b00: begin
                    state_d = IDLE;
                    entry_d = 1'b1;
                end
                2'b11:   state_d = IN_AB;
                2'b10:   state_d = ABORT;
                default: state_d = IN_B;
            endcase
            OUT_B: case ({a, b})
                2'b11:   state_d = OUT_BA;
                2'b00:   state_d = IDLE;
                2'b10:   state_d = ABORT;
                default: state_d = OUT_B;
            endcase
            OUT_BA: case ({a, b})
                2'b10:   state_d = OUT_A;
                2'b01:   state_d = OUT_B;
                2'b00:   state_d = ABORT;
                default: state_d = OUT_BA;
            endcase
            OUT_A: case ({a, b})
                2'b00: begin
                    state_d = IDLE;
                    exit_d  = 1'b1;
                end
                2'b11:   state_d = OUT_BA;
                2'b01:   state_d = ABORT;
                default: state_d = OUT_A;
            endcase
            ABORT: state_d = ({a, b} == 2'b00) ? IDLE : ABORT;
            default: state_d = ABORT;
        endcase

        // A stalled sequence is abandoned even if an edge arrives on the same cycle.
        if (state_q != IDLE && state_q != ABORT && dwell_q == DwellW'(TIMEOUT_CYCLES)) begin
            state_d = ABORT;
            entry_d = 1'b0;
            exit_d  = 1'b0;
        end
    end

    always_comb begin
        dwell_d = dwell_q;
        if (state_d != state_q) begin
            dwell_d = '0;
        end else if (dwell_q != DwellW'(TIMEOUT_CYCLES)) begin
            dwell_d = dwell_q + DwellW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            dwell_q <= '0;
            entry_q <= 1'b0;
            exit_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            entry_q <= entry_d;
            exit_q  <= exit_d;
        end
    end

    assign gate.entry_pulse = entry_q;
    assign gate.exit_pulse  = exit_q;
    assign gate.lane_busy   = (state_q != IDLE);

`ifdef GATE_FAULT_EN
    logic fault_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_q <= 1'b0;
        end else if (state_d == ABORT && state_q != ABORT) begin
            fault_q <= 1'b1;
        end else if (gate.fault_clr) begin
            fault_q <= 1'b0;
        end
    end

    assign gate.fault = fault_q;
`endif

endmodule

// File: tb/tb_gate_direction_detector.sv
// Scoreboard bench for gate_direction_detector (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64).
module tb_gate_direction_detector;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    typedef struct {
        bit is_entry;
        int at;
    } pulse_t;

    pulse_t exp_q[$];

    gate_direction_detector_if gate_bus ();

    gate_direction_detector #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .gate (gate_bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Four-edge sequence at 20-cycle spacing; completing pulse lands 67 cycles after the start.
    task automatic drive_seq(input bit is_entry, input bit want_pulse);
        int t0;
        t0 = cyc;
        if (want_pulse) exp_q.push_back('{is_entry, t0 + 67});
        if (is_entry) gate_bus.beam_a_raw = 1'b1; else gate_bus.beam_b_raw = 1'b1;
        step(20);
        check("busy_mid_sequence", int'(gate_bus.lane_busy), 1);
        if (is_entry) gate_bus.beam_b_raw = 1'b1; else gate_bus.beam_a_raw = 1'b1;
        step(20);
        if (is_entry) gate_bus.beam_a_raw = 1'b0; else gate_bus.beam_b_raw = 1'b0;
        step(20);
        if (is_entry) gate_bus.beam_b_raw = 1'b0; else gate_bus.beam_a_raw = 1'b0;
    endtask

    // Monitor: every pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (reset && (gate_bus.entry_pulse || gate_bus.exit_pulse)) begin
            check("pulse_exclusive", int'(gate_bus.entry_pulse & gate_bus.exit_pulse), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", gate_bus.entry_pulse ? 1 : 2, 0);
            end else begin
                pulse_t e;
                e = exp_q.pop_front();
                check("pulse_kind_entry", int'(gate_bus.entry_pulse), int'(e.is_entry));
                check("pulse_cycle", cyc, e.at);
            end
        end
    end

`ifdef GATE_FAULT_EN
    task automatic clear_fault();
        gate_bus.fault_clr = 1'b1;
        step(1);
        gate_bus.fault_clr = 1'b0;
        check("fault_cleared", int'(gate_bus.fault), 0);
    endtask
`endif

    initial begin
        bit busy_seen;
        bit level_seen;
        int t0;

        gate_bus.beam_a_raw = 1'b0;
        gate_bus.beam_b_raw = 1'b0;
`ifdef GATE_FAULT_EN
        gate_bus.fault_clr = 1'b0;
`endif
        #2;
        check("reset_entry", int'(gate_bus.entry_pulse), 0);
        check("reset_exit", int'(gate_bus.exit_pulse), 0);
        check("reset_busy", int'(gate_bus.lane_busy), 0);
`ifdef GATE_FAULT_EN
        check("reset_fault", int'(gate_bus.fault), 0);
`endif
        step(3);
        reset = 1'b1;
        step(5);

        // Clean entry, then clean exit.
        drive_seq(1'b1, 1'b1);
        step(20);
        check("entry_idle_after", int'(gate_bus.lane_busy), 0);
        drive_seq(1'b0, 1'b1);
        step(20);
        check("exit_idle_after", int'(gate_bus.lane_busy), 0);

        // Sub-debounce glitches must never reach the FSM.
        busy_seen  = 1'b0;
        level_seen = 1'b0;
        gate_bus.beam_a_raw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            busy_seen  |= gate_bus.lane_busy;
            level_seen |= dut.u_deb_a.level | dut.u_deb_b.level;
        end
        gate_bus.beam_a_raw = 1'b0;
        for (int k = 0; k < 4; k++) begin
            gate_bus.beam_b_raw = 1'b1;
            for (int i = 0; i < 3; i++) begin
                step(1);
                busy_seen  |= gate_bus.lane_busy;
                level_seen |= dut.u_deb_a.level | dut.u_deb_b.level;
            end
            gate_bus.beam_b_raw = 1'b0;
            for (int i = 0; i < 3; i++) begin
                step(1);
                busy_seen  |= gate_bus.lane_busy;
                level_seen |= dut.u_deb_a.level | dut.u_deb_b.level;
            end
        end
        step(10);
        busy_seen  |= gate_bus.lane_busy;
        level_seen |= dut.u_deb_a.level | dut.u_deb_b.level;
        check("glitch_busy", int'(busy_seen), 0);
        check("glitch_levels", int'(level_seen), 0);

        // Back-out: A only for 20 cycles.
        gate_bus.beam_a_raw = 1'b1;
        step(10);
        check("backout_busy", int'(gate_bus.lane_busy), 1);
        step(10);
        gate_bus.beam_a_raw = 1'b0;
        step(20);
        check("backout_idle", int'(gate_bus.lane_busy), 0);

        // Timeout: IN_A entered at t0+7, ABORT at t0+72.
        t0 = cyc;
        gate_bus.beam_a_raw = 1'b1;
        step(70);
        check("timeout_pre_busy", int'(gate_bus.lane_busy), 1);
`ifdef GATE_FAULT_EN
        step(1);
        check("timeout_fault_before", int'(gate_bus.fault), 0);
        step(1);
        check("timeout_fault_at", int'(gate_bus.fault), 1);
`else
        step(2);
`endif
        step(t0 + 100 - cyc);
        check("timeout_abort_busy", int'(gate_bus.lane_busy), 1);
        gate_bus.beam_a_raw = 1'b0;
        step(20);
        check("timeout_release_idle", int'(gate_bus.lane_busy), 0);
`ifdef GATE_FAULT_EN
        check("fault_sticky", int'(gate_bus.fault), 1);
        clear_fault();
`endif

        // After a timeout the rest of an entry order must not produce a pulse.
        gate_bus.beam_a_raw = 1'b1;
        step(100);
        gate_bus.beam_b_raw = 1'b1;
        step(20);
        gate_bus.beam_a_raw = 1'b0;
        step(20);
        gate_bus.beam_b_raw = 1'b0;
        step(20);
        check("timeout_then_order_idle", int'(gate_bus.lane_busy), 0);
`ifdef GATE_FAULT_EN
        clear_fault();
`endif

        // Ambiguous start: A and B together; release A first so a misrouted FSM would pulse.
        gate_bus.beam_a_raw = 1'b1;
        gate_bus.beam_b_raw = 1'b1;
        step(20);
        check("ambiguous_busy", int'(gate_bus.lane_busy), 1);
`ifdef GATE_FAULT_EN
        check("ambiguous_fault", int'(gate_bus.fault), 1);
`endif
        gate_bus.beam_a_raw = 1'b0;
        step(20);
        check("ambiguous_hold", int'(gate_bus.lane_busy), 1);
        gate_bus.beam_b_raw = 1'b0;
        step(20);
        check("ambiguous_idle", int'(gate_bus.lane_busy), 0);
`ifdef GATE_FAULT_EN
        clear_fault();
`endif
        drive_seq(1'b1, 1'b1);
        step(20);

        // Reset in the middle of IN_AB.
        gate_bus.beam_a_raw = 1'b1;
        step(20);
        gate_bus.beam_b_raw = 1'b1;
        step(10);
        check("pre_reset_busy", int'(gate_bus.lane_busy), 1);
        reset = 1'b0;
        #1;
        check("async_reset_busy", int'(gate_bus.lane_busy), 0);
        check("async_reset_entry", int'(gate_bus.entry_pulse), 0);
        check("async_reset_exit", int'(gate_bus.exit_pulse), 0);
        gate_bus.beam_a_raw = 1'b0;
        gate_bus.beam_b_raw = 1'b0;
        step(5);
        reset = 1'b1;
        step(20);
        check("post_reset_idle", int'(gate_bus.lane_busy), 0);

        drive_seq(1'b0, 1'b1);
        step(20);
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
